percept_front_if: RTL and testbench



---
 rtl/percept_pkg.sv | 18 +
 rtl/percept_front_shreg.sv | 25 ++
 rtl/percept_front_if.sv | 141 ++++++++++++++
 tb/tb_percept_front_if.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/percept_pkg.sv
// Shared types and constants for the percept serial front interface.
package percept_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 64;

  // Encoding of the R/W bit that follows the address field.
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RW   = 2'd2,
    ST_DATA = 2'd3
  } state_t;

endpackage

// File: rtl/percept_front_shreg.sv
// MSB-first shift register with parallel load; shifts sin into bit 0.
module percept_front_shreg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q
);

  // Load has priority over shift; reset is synchronous, active-high.
  always_ff @(posedge clk) begin
    if (nRst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {q[W-2:0], sin};
    end
  end

endmodule

// File: rtl/percept_front_if.sv
// Serial bus node: decodes start/address/RW/data frames, updates a data
// register on matching writes and serialises it onto a shared tri-state
// line on matching reads.
module percept_front_if
  import percept_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [ADDR_W-1:0] address,
  input  logic              in,
  output wire               out,
  output logic [DATA_W-1:0] data_q,
  output logic              wr_stb
);

  localparam int unsigned MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               match, match_n;
  logic               rw, rw_n;
  logic               oe, oe_n;
  logic               wr_n;
  logic               dq_load;
  logic               addr_shift;
  logic               data_shift;
  logic               data_load;
  logic [ADDR_W-1:0]  addr_sh;
  logic [DATA_W-1:0]  data_sh;

  // Address capture during the ADDR phase.
  percept_front_shreg #(.W(ADDR_W)) u_addr_sh (
    .clk      (clk),
    .nRst     (nRst),
    .load     (1'b0),
    .load_val ('0),
    .shift    (addr_shift),
    .sin      (in),
    .q        (addr_sh)
  );

  // Write capture and read serialisation share one register: a read loads
  // the data_q snapshot and shifts it out MSB-first; bits shifted in then
  // never reach the line.
  percept_front_shreg #(.W(DATA_W)) u_data_sh (
    .clk      (clk),
    .nRst     (nRst),
    .load     (data_load),
    .load_val (data_q),
    .shift    (data_shift),
    .sin      (in),
    .q        (data_sh)
  );

  // Only the addressed node ever drives the shared line.
  assign out = oe ? data_sh[DATA_W-1] : 1'bz;

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (nRst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      match  <= 1'b0;
      rw     <= 1'b0;
      oe     <= 1'b0;
      wr_stb <= 1'b0;
      data_q <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      match  <= match_n;
      rw     <= rw_n;
      oe     <= oe_n;
      wr_stb <= wr_n;
      if (dq_load) begin
        data_q <= {data_sh[DATA_W-2:0], in};
      end
    end
  end

  // Frame sequencing and per-phase control.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    match_n    = match;
    rw_n       = rw;
    oe_n       = oe;
    wr_n       = 1'b0;
    dq_load    = 1'b0;
    addr_shift = 1'b0;
    data_shift = 1'b0;
    data_load  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!in) begin
          state_n = ST_ADDR;
          cnt_n   = '0;
        end
      end
      ST_ADDR: begin
        addr_shift = 1'b1;
        if (cnt == CNT_W'(ADDR_W - 1)) begin
          cnt_n   = '0;
          state_n = ST_RW;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_RW: begin
        rw_n    = in;
        match_n = (addr_sh == address);
        cnt_n   = '0;
        state_n = ST_DATA;
        if ((in == RW_READ) && (addr_sh == address)) begin
          data_load = 1'b1;
          oe_n      = 1'b1;
        end
      end
      ST_DATA: begin
        data_shift = 1'b1;
        if (cnt == CNT_W'(DATA_W - 1)) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
          oe_n    = 1'b0;
          if ((rw == RW_WRITE) && match) begin
            dq_load = 1'b1;
            wr_n    = 1'b1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_percept_front_if.sv
// Directed bench: two nodes (8'h01, 8'hAA) on one shared in/out pair.
module tb_percept_front_if;

  logic        clk;
  logic        nRst;
  logic        in;
  wire         out_w;
  logic [63:0] dq_01;
  logic [63:0] dq_aa;
  logic        wr_01;
  logic        wr_aa;

  int n_cmp;
  int n_bad;
  int n_wr_01;
  int n_wr_aa;

  // Weak pull-up: an undriven shared line reads as 1.
  pullup (out_w);

  percept_front_if #(.ADDR_W(8), .DATA_W(64)) u_n01 (
    .clk     (clk),
    .nRst    (nRst),
    .address (8'h01),
    .in      (in),
    .out     (out_w),
    .data_q  (dq_01),
    .wr_stb  (wr_01)
  );

  percept_front_if #(.ADDR_W(8), .DATA_W(64)) u_naa (
    .clk     (clk),
    .nRst    (nRst),
    .address (8'hAA),
    .in      (in),
    .out     (out_w),
    .data_q  (dq_aa),
    .wr_stb  (wr_aa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles in which each write strobe is high.
  always @(posedge clk) begin
    if (wr_01 === 1'b1) n_wr_01++;
    if (wr_aa === 1'b1) n_wr_aa++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b);
    in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1);
    end
  endtask

  // Drive one full frame; check the shared line after every edge.
  // The reading node drives bit 63-(k-9) after edge Ek, k = 9..72.
  task automatic frame(input logic [7:0] a, input logic rwb, input logic [63:0] d,
                       input logic rd, input logic [63:0] rexp);
    logic [73:0] bits;
    logic        exp_o;
    bits = {1'b0, a, rwb, d};
    for (int k = 0; k < 74; k++) begin
      step(bits[73-k]);
      exp_o = (rd && k >= 9 && k <= 72) ? rexp[63-(k-9)] : 1'b1;
      chk($sformatf("out_k%0d", k), {63'd0, out_w}, {63'd0, exp_o});
    end
  endtask

  initial begin
    logic [73:0] ab;
    n_cmp   = 0;
    n_bad   = 0;
    n_wr_01 = 0;
    n_wr_aa = 0;
    in      = 1'b1;
    nRst    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dq01", dq_01, 64'd0);
    chk("rst_dqaa", dq_aa, 64'd0);
    chk("rst_wr", {62'd0, wr_01, wr_aa}, 64'd0);
    chk("rst_out", {63'd0, out_w}, 64'd1);
    nRst = 1'b0;
    idle(2);

    // Write to an absent address, data 0.
    frame(8'h10, 1'b1, 64'd0, 1'b0, 64'd0);
    idle(2);
    chk("w10a_dq01", dq_01, 64'd0);
    chk("w10a_dqaa", dq_aa, 64'd0);
    chk("w10a_wr01", 64'(n_wr_01), 64'd0);
    chk("w10a_wraa", 64'(n_wr_aa), 64'd0);

    // Write to an absent address, alternating data.
    frame(8'h10, 1'b1, 64'hAAAAAAAAAAAAAAAA, 1'b0, 64'd0);
    idle(2);
    chk("w10b_dq01", dq_01, 64'd0);
    chk("w10b_dqaa", dq_aa, 64'd0);
    chk("w10b_wr", 64'(n_wr_01 + n_wr_aa), 64'd0);

    // Write to node AA.
    frame(8'hAA, 1'b1, 64'h0101010101010101, 1'b0, 64'd0);
    chk("waa_stb", {62'd0, wr_01, wr_aa}, 64'd1);
    idle(2);
    chk("waa_dqaa", dq_aa, 64'h0101010101010101);
    chk("waa_dq01", dq_01, 64'd0);
    chk("waa_wraa", 64'(n_wr_aa), 64'd1);
    chk("waa_wr01", 64'(n_wr_01), 64'd0);

    // Read node AA; in carries noise during the data phase.
    frame(8'hAA, 1'b0, 64'h5A5A_F00F_1234_8001, 1'b1, 64'h0101010101010101);
    idle(2);
    chk("raa_dqaa", dq_aa, 64'h0101010101010101);
    chk("raa_out", {63'd0, out_w}, 64'd1);
    chk("raa_wr", 64'(n_wr_01 + n_wr_aa), 64'd1);

    // Reset while data bit 30 of a write to AA is on the line.
    ab = {1'b0, 8'hAA, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    for (int k = 0; k < 43; k++) begin
      step(ab[73-k]);
    end
    nRst = 1'b1;
    step(1'b1);
    nRst = 1'b0;
    chk("abort_dqaa", dq_aa, 64'd0);
    chk("abort_out", {63'd0, out_w}, 64'd1);
    idle(3);
    chk("abort_dqaa2", dq_aa, 64'd0);
    chk("abort_wr", 64'(n_wr_aa), 64'd1);

    // Full frame after the aborted one is accepted.
    frame(8'hAA, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'd0);
    idle(2);
    chk("post_dqaa", dq_aa, 64'h1234_5678_9ABC_DEF0);
    chk("post_wraa", 64'(n_wr_aa), 64'd2);

    // Back-to-back writes, no idle cycle between frames.
    frame(8'h01, 1'b1, 64'hDEAD_BEEF_00C0_FFEE, 1'b0, 64'd0);
    frame(8'hAA, 1'b1, 64'h0F0F_0F0F_F0F0_F0F0, 1'b0, 64'd0);
    idle(2);
    chk("b2b_dq01", dq_01, 64'hDEAD_BEEF_00C0_FFEE);
    chk("b2b_dqaa", dq_aa, 64'h0F0F_0F0F_F0F0_F0F0);
    chk("b2b_wr01", 64'(n_wr_01), 64'd1);
    chk("b2b_wraa", 64'(n_wr_aa), 64'd3);

    // Read node 01: it drives, AA stays off the line.
    frame(8'h01, 1'b0, 64'd0, 1'b1, 64'hDEAD_BEEF_00C0_FFEE);
    idle(2);
    chk("r01_dq01", dq_01, 64'hDEAD_BEEF_00C0_FFEE);
    chk("r01_out", {63'd0, out_w}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
